// File: rtl/tpumac_row_if.sv
// rtl/tpumac_row_if.sv - control, operand and result bundle of the systolic MAC row
interface tpumac_row_if #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 16,
    parameter int COLS   = 4,
    parameter int CNT_W  = 8
);
    logic                    en;
    logic                    WrEn;
    logic                    clr;
    logic                    sat_en;
    logic [DATA_W-1:0]       Ain;
    logic [COLS*DATA_W-1:0]  Bin;
    logic [COLS*ACC_W-1:0]   Cin;
    logic [DATA_W-1:0]       Aout;
    logic [COLS*DATA_W-1:0]  Bout;
    logic [COLS*ACC_W-1:0]   Cout;
    logic [COLS-1:0]         sat_flag;
    logic [CNT_W-1:0]        mac_cnt;

    modport master (
        output en, WrEn, clr, sat_en, Ain, Bin, Cin,
        input  Aout, Bout, Cout, sat_flag, mac_cnt
    );

    modport slave (
        input  en, WrEn, clr, sat_en, Ain, Bin, Cin,
        output Aout, Bout, Cout, sat_flag, mac_cnt
    );
endinterface

// File: rtl/tpumac_row.sv
// rtl/tpumac_row.sv - 1-D systolic row of MAC cells sharing one skewed A stream
module tpumac_row #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 16,
    parameter int COLS   = 4,
    parameter int CNT_W  = 8
) (
    input  logic          clk,
    input  logic          rst,
    tpumac_row_if.slave   bus
);
    localparam int SUM_W = ACC_W + 1;
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    // The one-bit headroom in the sum only covers a full-width product if the
    // accumulator is at least twice the operand width.
    if (ACC_W < 2*DATA_W) begin : g_acc_w_check
        $error("tpumac_row: ACC_W must be >= 2*DATA_W");
    end
    if (COLS < 1) begin : g_cols_check
        $error("tpumac_row: COLS must be >= 1");
    end

    logic signed [DATA_W-1:0]   a_q     [COLS];
    logic signed [DATA_W-1:0]   b_q     [COLS];
    logic signed [ACC_W-1:0]    acc_q   [COLS];
    logic [COLS-1:0]            sat_q;
    logic [CNT_W-1:0]           cnt_q;

    logic signed [DATA_W-1:0]   a_in    [COLS];
    logic signed [DATA_W-1:0]   b_in    [COLS];
    logic signed [2*DATA_W-1:0] prod    [COLS];
    logic signed [SUM_W-1:0]    sum     [COLS];
    logic signed [ACC_W-1:0]    acc_nxt [COLS];
    logic [COLS-1:0]            ovf;

    // Per-column operand selection, MAC sum and overflow handling for an enabled cycle.
    always_comb begin
        ovf = '0;
        a_in[0] = bus.Ain;
        for (int c = 1; c < COLS; c++) begin
            a_in[c] = a_q[c-1];
        end
        for (int c = 0; c < COLS; c++) begin
            b_in[c] = bus.Bin[c*DATA_W +: DATA_W];
            prod[c] = a_in[c] * b_in[c];
            sum[c]  = SUM_W'(acc_q[c]) + SUM_W'(prod[c]);
            // The two top bits of the widened sum disagree exactly when it leaves the ACC_W range.
            ovf[c]  = sum[c][ACC_W] ^ sum[c][ACC_W-1];
            if (ovf[c] && bus.sat_en) begin
                acc_nxt[c] = sum[c][ACC_W] ? ACC_MIN : ACC_MAX;
            end else begin
                acc_nxt[c] = sum[c][ACC_W-1:0];
            end
        end
    end

    // State update with priority rst > clr > WrEn > en; nothing asserted holds all state.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < COLS; c++) begin
                a_q[c]   <= '0;
                b_q[c]   <= '0;
                acc_q[c] <= '0;
            end
            sat_q <= '0;
            cnt_q <= '0;
        end else if (bus.clr) begin
            for (int c = 0; c < COLS; c++) begin
                acc_q[c] <= '0;
            end
            sat_q <= '0;
            cnt_q <= '0;
        end else if (bus.WrEn) begin
            for (int c = 0; c < COLS; c++) begin
                acc_q[c] <= bus.Cin[c*ACC_W +: ACC_W];
            end
            sat_q <= '0;
            cnt_q <= '0;
        end else if (bus.en) begin
            for (int c = 0; c < COLS; c++) begin
                a_q[c]   <= a_in[c];
                b_q[c]   <= b_in[c];
                acc_q[c] <= acc_nxt[c];
            end
            sat_q <= sat_q | ovf;
            if (cnt_q != '1) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.Aout     = a_q[COLS-1];
    assign bus.sat_flag = sat_q;
    assign bus.mac_cnt  = cnt_q;

    for (genvar c = 0; c < COLS; c++) begin : g_pack
        assign bus.Bout[c*DATA_W +: DATA_W] = b_q[c];
        assign bus.Cout[c*ACC_W +: ACC_W]   = acc_q[c];
    end
endmodule
